pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, meaning the PLL reset pulse width in cycles (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, meaning the cycles to wait for lock before re-resetting the PLL (>=2).
REQ-003 SHALL have parameter FILTER_CYCLES, default 1024, meaning the consecutive synchronized-lock-high cycles required (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 256, meaning the cycles sys_reset_n stays low after the filter passes (>=1).
REQ-005 SHALL have port clock, input, 1, free-running reference clock (PLL input clock, not PLL output); the block's only clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pll_lock, input, 1, PLL LOCK output, asynchronous to clock.
REQ-008 SHALL have port clr_status, input, 1, single-cycle pulse clearing lock_lost and retry_count.
REQ-009 SHALL have port pll_rst, output, 1, active-high reset to the PLL RST pin.
REQ-010 SHALL have port sys_reset_n, output, 1, active-low system reset request.
REQ-011 SHALL have port ready, output, 1, high only in RUN.
REQ-012 SHALL have port retry_count, output, 4, saturating count of lock timeouts.
REQ-013 SHALL have port lock_lost, output, 1, sticky flag set when lock drops after FILTER passed.

Function
REQ-014 SHALL synchronize pll_lock through two flops; lock_s is the second flop output, so lock_s lags pll_lock by 2 cycles.
REQ-015 SHALL have states RESET_PLL, WAIT_LOCK, FILTER, HOLD, RUN, with one shared counter cleared to 0 on every state entry and incremented each cycle while in a state.
REQ-016 In RESET_PLL, pll_rst SHALL be 1; when the counter == RST_CYCLES-1 the block SHALL go to WAIT_LOCK (pll_rst high exactly RST_CYCLES cycles).
REQ-017 In WAIT_LOCK, lock_s=1 SHALL go to FILTER; otherwise counter == LOCK_TIMEOUT-1 SHALL go to RESET_PLL and increment retry_count, saturating at 15.
REQ-018 In FILTER, lock_s=0 SHALL return to WAIT_LOCK (timeout restarts); counter == FILTER_CYCLES-1 with lock_s=1 SHALL go to HOLD.
REQ-019 In HOLD, lock_s=0 SHALL go to RESET_PLL and set lock_lost; counter == HOLD_CYCLES-1 with lock_s=1 SHALL go to RUN.
REQ-020 In RUN, lock_s=0 SHALL go to RESET_PLL and set lock_lost; otherwise stay in RUN with the counter frozen.
REQ-021 sys_reset_n SHALL be a registered output, 1 only while in RUN; ready SHALL equal the in-RUN state; pll_rst SHALL be registered and 1 only in RESET_PLL.
REQ-022 On lock loss in RUN, sys_reset_n SHALL fall on the same edge where the state leaves RUN (3 cycles after pll_lock falls).
REQ-023 clr_status SHALL clear lock_lost and retry_count; a simultaneous set/increment in the same cycle SHALL take priority (result lock_lost=1 / retry_count=1).
REQ-024 The counter SHALL be wide enough for the largest parameter minus 1 and SHALL never wrap within a state.

Reset
REQ-025 While reset_n=0, asynchronously: state RESET_PLL, counter 0, sync flops 0, pll_rst=1, sys_reset_n=0, ready=0, retry_count=0, lock_lost=0.
REQ-026 After reset_n deasserts, the RST_CYCLES count SHALL start on the first clock edge; reset asserted mid-sequence (any state) SHALL restart from RESET_PLL with all status cleared.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, FILTER_CYCLES=8, HOLD_CYCLES=4)
REQ-027 Release reset, pll_lock=1 constant -> pll_rst high 4 cycles; sys_reset_n/ready rise once after WAIT_LOCK + 2-cycle sync + 8 + 4 cycles; retry_count=0, lock_lost=0.
REQ-028 pll_lock held 0 for 250 cycles -> pll_rst re-pulses every 104 cycles, retry_count=2 at cycle 250; after 16 timeouts retry_count stays 15.
REQ-029 pll_lock glitches low for 1 cycle during FILTER -> return to WAIT_LOCK, filter restarts, lock_lost stays 0, sys_reset_n stays 0.
REQ-030 In RUN, pll_lock drops -> 3 cycles later sys_reset_n=0, ready=0, pll_rst=1 for 4 cycles, lock_lost=1; clr_status pulse -> lock_lost=0, retry_count=0.
REQ-031 clr_status coincident with a timeout increment -> retry_count=1; reset_n pulsed low during HOLD -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer. It pulses the PLL reset, waits for LOCK, checks that
// LOCK stays high for a while, then holds the system reset for a while
// longer before it releases the system. If LOCK is lost, or never arrives,
// the sequence starts again from the PLL reset.
//
// Ports:
//   clock       - free-running reference clock (the PLL input, not its output)
//   reset_n     - asynchronous active-low reset
//   pll_lock    - PLL LOCK output, asynchronous to clock
//   clr_status  - one-cycle pulse that clears lock_lost and retry_count
//   pll_rst     - active-high reset to the PLL RST pin
//   sys_reset_n - active-low system reset request, released only in RUN
//   ready       - high while in RUN
//   retry_count - number of lock timeouts, saturates at 15
//   lock_lost   - sticky flag, set when lock drops after the filter has passed
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int FILTER_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       clr_status,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic       lock_lost
);

  // The counter must reach the largest terminal value (largest parameter - 1).
  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (FILTER_CYCLES > HOLD_CYCLES) ? FILTER_CYCLES : HOLD_CYCLES;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FLT_LAST  = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, FILTER, HOLD, RUN} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          sync1, lock_s;
  logic          lost_set, retry_inc;

  // Two-flop synchronizer. lock_s lags pll_lock by two cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end

  always_comb begin
    nxt       = state;
    lost_set  = 1'b0;
    retry_inc = 1'b0;
    case (state)
      RESET_PLL: if (cnt == RST_LAST) nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) nxt = FILTER;
        else if (cnt == TO_LAST) begin
          nxt       = RESET_PLL;
          retry_inc = 1'b1;
        end
      end
      // A single low sample sends the filter back to WAIT_LOCK, where the
      // timeout starts again from zero.
      FILTER: begin
        if (!lock_s) nxt = WAIT_LOCK;
        else if (cnt == FLT_LAST) nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          nxt      = RESET_PLL;
          lost_set = 1'b1;
        end else if (cnt == HOLD_LAST) nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          nxt      = RESET_PLL;
          lost_set = 1'b1;
        end
      end
      default: nxt = RESET_PLL;
    endcase
  end

  // The outputs are decoded from the next state, so they change on the same
  // edge as the state does.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      retry_count <= 4'd0;
      lock_lost   <= 1'b0;
    end else begin
      state <= nxt;
      // The counter clears on every state entry. It stays frozen in RUN.
      // In every other state the exit fires at the terminal count, so the
      // counter cannot wrap.
      if (nxt != state)  cnt <= '0;
      else if (state != RUN) cnt <= cnt + CW'(1);
      pll_rst     <= (nxt == RESET_PLL);
      sys_reset_n <= (nxt == RUN);
      ready       <= (nxt == RUN);
      // When a set or increment arrives in the same cycle as a clear, the
      // set or increment wins. The cleared value is then counted up by one.
      if (retry_inc) begin
        if (clr_status)              retry_count <= 4'd1;
        else if (retry_count != 4'hF) retry_count <= retry_count + 4'd1;
      end else if (clr_status) retry_count <= 4'd0;
      if (lost_set)        lock_lost <= 1'b1;
      else if (clr_status) lock_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer, built with small parameters
// (RST=4, TIMEOUT=100, FILTER=8, HOLD=4). Every input is driven and every
// output is sampled on the falling clock edge. "Edge N" means the Nth rising
// edge after reset_n is released.
module tb_pll_lock_sequencer;
  logic       clock, reset_n, pll_lock, clr_status;
  logic       pll_rst, sys_reset_n, ready, lock_lost;
  logic [3:0] retry_count;
  int total = 0;
  int bad   = 0;

  pll_lock_sequencer #(.RST_CYCLES(4), .LOCK_TIMEOUT(100), .FILTER_CYCLES(8), .HOLD_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock), .clr_status(clr_status),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .ready(ready),
    .retry_count(retry_count), .lock_lost(lock_lost));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Resets the DUT and returns at the falling edge where reset_n is released.
  task automatic do_reset(input logic lk);
    @(negedge clock);
    reset_n = 1'b0; pll_lock = lk; clr_status = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_lock = 1'b0; clr_status = 1'b0;
    cyc(2);
    total++; if (pll_rst !== 1'b1)     begin bad++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    total++; if (sys_reset_n !== 1'b0) begin bad++; $display("FAIL rst_sys got=%b exp=0", sys_reset_n); end
    total++; if (ready !== 1'b0)       begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL rst_retry got=%0d exp=0", retry_count); end
    total++; if (lock_lost !== 1'b0)   begin bad++; $display("FAIL rst_lost got=%b exp=0", lock_lost); end
  endtask

  // LOCK is high the whole time. WAIT_LOCK is entered at edge 4, FILTER at
  // edge 5, HOLD at edge 13 and RUN at edge 17.
  task automatic test_lock_up();
    do_reset(1'b1);
    cyc(3);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL up_pll_rst_e3 got=%b exp=1", pll_rst); end
    cyc(1);
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL up_pll_rst_e4 got=%b exp=0", pll_rst); end
    cyc(12);
    total++; if (sys_reset_n !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL up_e16 sys=%b ready=%b exp=0/0", sys_reset_n, ready); end
    cyc(1);
    total++; if (sys_reset_n !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL up_e17 sys=%b ready=%b exp=1/1", sys_reset_n, ready); end
    total++; if (retry_count !== 4'd0 || lock_lost !== 1'b0) begin bad++; $display("FAIL up_status retry=%0d lost=%b exp=0/0", retry_count, lock_lost); end
    cyc(20);
    total++; if (ready !== 1'b1 || pll_rst !== 1'b0) begin bad++; $display("FAIL up_stay ready=%b pll_rst=%b exp=1/0", ready, pll_rst); end
  endtask

  // LOCK never arrives. The timeouts land at edges 104*k.
  task automatic test_timeout();
    do_reset(1'b0);
    cyc(103);
    total++; if (pll_rst !== 1'b0 || retry_count !== 4'd0) begin bad++; $display("FAIL to_e103 pll_rst=%b retry=%0d exp=0/0", pll_rst, retry_count); end
    cyc(1);
    total++; if (pll_rst !== 1'b1 || retry_count !== 4'd1) begin bad++; $display("FAIL to_e104 pll_rst=%b retry=%0d exp=1/1", pll_rst, retry_count); end
    cyc(3);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_e107 pll_rst=%b exp=1", pll_rst); end
    cyc(1);
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL to_e108 pll_rst=%b exp=0", pll_rst); end
    cyc(99);
    total++; if (retry_count !== 4'd1 || pll_rst !== 1'b0) begin bad++; $display("FAIL to_e207 retry=%0d pll_rst=%b exp=1/0", retry_count, pll_rst); end
    cyc(1);
    total++; if (retry_count !== 4'd2 || pll_rst !== 1'b1) begin bad++; $display("FAIL to_e208 retry=%0d pll_rst=%b exp=2/1", retry_count, pll_rst); end
    cyc(42);
    total++; if (retry_count !== 4'd2) begin bad++; $display("FAIL to_e250 retry=%0d exp=2", retry_count); end
    cyc(1310);
    total++; if (retry_count !== 4'd15) begin bad++; $display("FAIL to_e1560 retry=%0d exp=15", retry_count); end
    cyc(240);
    total++; if (retry_count !== 4'd15) begin bad++; $display("FAIL to_sat retry=%0d exp=15", retry_count); end
  endtask

  // LOCK dips low for one cycle while in FILTER. lock_s is low only during
  // the cycle after edge 9, so the FSM falls back to WAIT_LOCK at edge 10,
  // re-enters FILTER at 11, HOLD at 19 and RUN at 23.
  task automatic test_glitch();
    do_reset(1'b1);
    cyc(7);
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;
    cyc(9);
    total++; if (sys_reset_n !== 1'b0) begin bad++; $display("FAIL gl_e17 sys=%b exp=0", sys_reset_n); end
    cyc(5);
    total++; if (sys_reset_n !== 1'b0 || ready !== 1'b0 || lock_lost !== 1'b0 || pll_rst !== 1'b0)
      begin bad++; $display("FAIL gl_e22 sys=%b ready=%b lost=%b pll_rst=%b exp=0/0/0/0", sys_reset_n, ready, lock_lost, pll_rst); end
    cyc(1);
    total++; if (sys_reset_n !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL gl_e23 sys=%b ready=%b exp=1/1", sys_reset_n, ready); end
  endtask

  // LOCK drops after edge 20, while in RUN. The FSM leaves RUN at edge 23.
  task automatic test_lock_loss();
    do_reset(1'b1);
    cyc(20);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ll_run ready=%b exp=1", ready); end
    pll_lock = 1'b0;
    cyc(2);
    total++; if (sys_reset_n !== 1'b1) begin bad++; $display("FAIL ll_e22 sys=%b exp=1", sys_reset_n); end
    cyc(1);
    total++; if (sys_reset_n !== 1'b0 || ready !== 1'b0 || pll_rst !== 1'b1 || lock_lost !== 1'b1)
      begin bad++; $display("FAIL ll_e23 sys=%b ready=%b pll_rst=%b lost=%b exp=0/0/1/1", sys_reset_n, ready, pll_rst, lock_lost); end
    cyc(3);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL ll_e26 pll_rst=%b exp=1", pll_rst); end
    cyc(1);
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL ll_e27 pll_rst=%b exp=0", pll_rst); end
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    total++; if (lock_lost !== 1'b0 || retry_count !== 4'd0) begin bad++; $display("FAIL ll_clr lost=%b retry=%0d exp=0/0", lock_lost, retry_count); end
  endtask

  // clr_status arrives in the same cycle as the second timeout, at edge 208.
  task automatic test_clr_collision();
    do_reset(1'b0);
    cyc(207);
    total++; if (retry_count !== 4'd1) begin bad++; $display("FAIL cc_pre retry=%0d exp=1", retry_count); end
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    total++; if (retry_count !== 4'd1 || pll_rst !== 1'b1) begin bad++; $display("FAIL cc_hit retry=%0d pll_rst=%b exp=1/1", retry_count, pll_rst); end
    cyc(2);
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL cc_clr retry=%0d exp=0", retry_count); end
  endtask

  // LOCK drops in HOLD (entered at edge 13) and the FSM leaves HOLD at edge
  // 16. The second pass reaches HOLD at edge 29, and reset_n is then pulsed
  // after edge 31.
  task automatic test_hold_reset();
    do_reset(1'b1);
    cyc(13);
    pll_lock = 1'b0;
    cyc(3);
    total++; if (pll_rst !== 1'b1 || lock_lost !== 1'b1 || sys_reset_n !== 1'b0)
      begin bad++; $display("FAIL hd_drop pll_rst=%b lost=%b sys=%b exp=1/1/0", pll_rst, lock_lost, sys_reset_n); end
    pll_lock = 1'b1;
    cyc(15);
    total++; if (pll_rst !== 1'b0 || lock_lost !== 1'b1 || sys_reset_n !== 1'b0)
      begin bad++; $display("FAIL hd_e31 pll_rst=%b lost=%b sys=%b exp=0/1/0", pll_rst, lock_lost, sys_reset_n); end
    reset_n = 1'b0;
    #1;
    total++; if (pll_rst !== 1'b1 || sys_reset_n !== 1'b0 || ready !== 1'b0 || lock_lost !== 1'b0 || retry_count !== 4'd0)
      begin bad++; $display("FAIL hd_async pll_rst=%b sys=%b ready=%b lost=%b retry=%0d exp=1/0/0/0/0", pll_rst, sys_reset_n, ready, lock_lost, retry_count); end
    cyc(1);
    reset_n = 1'b1;
    cyc(16);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL hd_re_e16 ready=%b exp=0", ready); end
    cyc(1);
    total++; if (ready !== 1'b1 || lock_lost !== 1'b0) begin bad++; $display("FAIL hd_re_e17 ready=%b lost=%b exp=1/0", ready, lock_lost); end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_clr_collision();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
